// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: converts the host command controller's single-word
// address/data handshake into one-at-a-time AXI4-Lite master transactions.
// Optional watchdog enabled by defining AXI_BRIDGE_TIMEOUT_EN.
module axi4_lite_master_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_addr_valid,
  input  logic                i_write_enable,
  input  logic                i_write_data_valid,
  input  logic [31:0]         i_common,
  output logic                o_addr_ready,
  output logic                o_write_data_ready,
  output logic                o_read_data_valid,
  input  logic                i_read_data_ready,
  output logic [DATA_W-1:0]   o_read_data,
  output logic                o_rd_err,
  output logic                o_wr_err,
  input  logic                i_err_clear,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WAIT_WDATA, WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP, READ_HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              aw_fin, w_fin;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign o_addr_ready       = reset_n && (state == IDLE) && i_addr_valid;
  assign o_write_data_ready = reset_n && (state == WAIT_WDATA) && i_write_data_valid;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = data_q;
  assign m_axi_awprot = '0;
  assign m_axi_arprot = '0;
  assign m_axi_wstrb  = '1;

`ifdef AXI_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             timed, leaving, timeout;

  assign timed   = state inside {WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP};
  assign leaving = (state == WRITE_REQ  && aw_fin && w_fin) ||
                   (state == WRITE_RESP && b_hs) ||
                   (state == READ_REQ   && ar_hs) ||
                   (state == READ_RESP  && r_hs);
  // A handshake in the final cycle counts as progress, not as a timeout.
  assign timeout = timed && !leaving && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent in one waiting state, clears on any state change.
  always_ff @(posedge clk) begin
    if (!reset_n) tmo_cnt <= '0;
    else          tmo_cnt <= (timed && !leaving && !timeout) ? tmo_cnt + 1'b1 : '0;
  end
`endif

  // Transaction FSM; AXI valid/ready are registered decodes of the current state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      addr_q            <= '0;
      data_q            <= '0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      m_axi_awvalid     <= 1'b0;
      m_axi_wvalid      <= 1'b0;
      m_axi_bready      <= 1'b0;
      m_axi_arvalid     <= 1'b0;
      m_axi_rready      <= 1'b0;
      o_read_data       <= '0;
      o_read_data_valid <= 1'b0;
      o_rd_err          <= 1'b0;
      o_wr_err          <= 1'b0;
    end else begin
      // Clear first; any error set below in the same cycle overrides it.
      if (i_err_clear) begin
        o_rd_err <= 1'b0;
        o_wr_err <= 1'b0;
      end
      m_axi_awvalid <= (state == WRITE_REQ) && !aw_fin;
      m_axi_wvalid  <= (state == WRITE_REQ) && !w_fin;
      aw_done       <= (state == WRITE_REQ) && aw_fin && !w_fin;
      w_done        <= (state == WRITE_REQ) && w_fin && !aw_fin;
      m_axi_bready  <= (state == WRITE_RESP) && !b_hs;
      m_axi_arvalid <= (state == READ_REQ) && !ar_hs;
      m_axi_rready  <= (state == READ_RESP) && !r_hs;
      case (state)
        IDLE: if (i_addr_valid) begin
          addr_q <= i_common[ADDR_W-1:0];
          state  <= i_write_enable ? WAIT_WDATA : READ_REQ;
        end
        WAIT_WDATA: if (i_write_data_valid) begin
          data_q <= i_common[DATA_W-1:0];
          state  <= WRITE_REQ;
        end
        WRITE_REQ: if (aw_fin && w_fin) state <= WRITE_RESP;
        WRITE_RESP: if (b_hs) begin
          if (m_axi_bresp != 2'b00) o_wr_err <= 1'b1;
          state <= IDLE;
        end
        READ_REQ: if (ar_hs) state <= READ_RESP;
        READ_RESP: if (r_hs) begin
          o_read_data       <= m_axi_rdata;
          o_read_data_valid <= 1'b1;
          if (m_axi_rresp != 2'b00) o_rd_err <= 1'b1;
          state <= READ_HOLD;
        end
        READ_HOLD: if (i_read_data_ready) begin
          o_read_data_valid <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_BRIDGE_TIMEOUT_EN
      if (timeout) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        if (state == READ_REQ || state == READ_RESP) begin
          o_rd_err          <= 1'b1;
          o_read_data       <= DATA_W'(32'hDEADBEEF);
          o_read_data_valid <= 1'b1;
          state             <= READ_HOLD;
        end else begin
          o_wr_err <= 1'b1;
          state    <= IDLE;
        end
      end
`endif
    end
  end

endmodule
